// File: rtl/fifo_pkg.sv
// Shared FIFO controller definitions: state encoding reused by the read/write FSMs.
package fifo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_OWN   = 2'd1;
  localparam state_t ST_STALL = 2'd2;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request/data bundle and FIFO write-port outputs of the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic               full;
  logic [NREQ-1:0]    gnt;
  logic               push;
  logic [DW-1:0]      dout;
  logic [IDW-1:0]     src_id;
  logic               busy;

  modport master (
    input  req, din, full,
    output gnt, push, dout, src_id, busy
  );

  modport slave (
    output req, din, full,
    input  gnt, push, dout, src_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping,
// with 'last' itself checked at the very end of the scan.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int unsigned IDW = $clog2(NREQ);

  int unsigned pos;

  // Explicit subtract-wrap keeps the scan correct for non-power-of-two NREQ.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = 32'(last) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos[IDW-1:0]]) begin
        any = 1'b1;
        idx = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// honouring the FIFO full flag and capping each grant at BURST words.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic              clk,
  input  logic              arst,
  fifo_wr_arbiter_if.master bus
);
  import fifo_pkg::*;

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(BURST + 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q,  last_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  logic [IDW-1:0] pick_last;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           own_req;
  logic           push_c;
  logic           release_c;
  logic [DW-1:0]  words [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) words[i] = bus.din[i*DW +: DW];
  end

  // In IDLE the scan resumes after the previous owner; on release it starts
  // after the current owner, which equals the last value about to be written.
  assign pick_last = (state_q == ST_IDLE) ? last_q : owner_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req),
    .last (pick_last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign own_req = bus.req[owner_q];
  assign push_c  = (state_q == ST_OWN) && own_req && !bus.full;

  always_comb begin
    bus.gnt = '0;
    if (push_c) bus.gnt[owner_q] = 1'b1;
  end

  assign bus.push   = push_c;
  assign bus.dout   = push_c ? words[owner_q] : '0;
  assign bus.src_id = owner_q;
  assign bus.busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!own_req)                      release_c = 1'b1;
        else if (bus.full)                 state_d   = ST_STALL;
        else if (cnt_q == CW'(BURST - 1))  release_c = 1'b1;
        else                               cnt_d     = cnt_q + CW'(1);
      end
      ST_STALL: begin
        if (!own_req)       release_c = 1'b1;
        else if (!bus.full) state_d   = ST_OWN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (release_c) begin
      last_d = owner_q;
      cnt_d  = '0;
      if (pick_any) begin
        owner_d = pick_idx;
        state_d = ST_OWN;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a behavioural
// producer/arbiter model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: is a producer holding the port, is it waiting on full, who holds it,
  // who held it last, how many words of its burst are used.
  bit m_hold, m_stall;
  int m_own, m_last, m_used;

  logic [DW-1:0]   data [NREQ][16];
  int              len  [NREQ];
  int              ptr  [NREQ];
  logic [NREQ-1:0] drop_mask;
  logic            full_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int lst, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int p;
      p = (lst + k) % NREQ;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_stall = 0; m_own = 0; m_last = NREQ - 1; m_used = 0;
  endtask

  task automatic load(input int i, input int n, input int base);
    len[i] = n;
    ptr[i] = 0;
    for (int k = 0; k < 16; k++) data[i][k] = 8'(base + k);
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic step();
    logic [NREQ-1:0]    r;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    e_gnt;
    logic [DW-1:0]      e_dout;
    bit                 e_push, rel;
    int                 np;
    for (int i = 0; i < NREQ; i++) begin
      r[i] = (ptr[i] < len[i]) && !drop_mask[i];
      d[i*DW +: DW] = (ptr[i] < len[i]) ? data[i][ptr[i]] : '0;
    end
    bus.req  = r;
    bus.din  = d;
    bus.full = full_v;
    #3;
    e_push = m_hold && !m_stall && r[m_own] && !full_v;
    e_gnt  = '0;
    if (e_push) e_gnt[m_own] = 1'b1;
    e_dout = e_push ? d[m_own*DW +: DW] : '0;
    chk("push",   32'(bus.push),   32'(e_push));
    chk("gnt",    32'(bus.gnt),    32'(e_gnt));
    chk("dout",   32'(bus.dout),   32'(e_dout));
    chk("src_id", 32'(bus.src_id), m_own);
    chk("busy",   32'(bus.busy),   32'(m_hold));

    if (e_push) ptr[m_own]++;
    rel = 0;
    if (!m_hold) begin
      np = pick(m_last, r);
      if (np >= 0) begin m_hold = 1; m_stall = 0; m_own = np; m_used = 0; end
    end else if (!r[m_own]) rel = 1;
    else if (m_stall) begin
      if (!full_v) m_stall = 0;
    end else if (full_v) m_stall = 1;
    else begin
      m_used++;
      if (m_used == BURST) rel = 1;
    end
    if (rel) begin
      m_last = m_own; m_used = 0; m_stall = 0;
      np = pick(m_last, r);
      if (np >= 0) m_own = np;
      else m_hold = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arst     = 1'b1;
    full_v   = 1'b0;
    drop_mask = '0;
    bus.req  = '0;
    bus.din  = '0;
    bus.full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin len[i] = 0; ptr[i] = 0; end
    model_reset();
    #2;
    chk("rst_push",   32'(bus.push),   0);
    chk("rst_gnt",    32'(bus.gnt),    0);
    chk("rst_dout",   32'(bus.dout),   0);
    chk("rst_src_id", 32'(bus.src_id), 0);
    chk("rst_busy",   32'(bus.busy),   0);
    @(posedge clk); @(posedge clk); #1;
    arst = 1'b0;
  endtask

  initial begin
    // 1: single producer, burst cap then sole-requester re-grant
    do_reset();
    load(0, 6, 'hA0);
    repeat (10) step();

    // 2: all four producers, six words each
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 6, 16 * (i + 1));
    repeat (32) step();

    // 3: full for three cycles mid-burst of producer 1
    do_reset();
    load(1, 6, 'h50);
    load(2, 2, 'h60);
    repeat (3) step();
    full_v = 1'b1;
    repeat (3) step();
    full_v = 1'b0;
    repeat (10) step();

    // 4: owner runs dry after one word while producer 3 waits
    do_reset();
    load(1, 1, 'h70);
    load(3, 3, 'h80);
    repeat (7) step();

    // 5: full rises in the same cycle the owner withdraws
    do_reset();
    load(0, 6, 'h90);
    load(2, 3, 'hB0);
    repeat (2) step();
    drop_mask[0] = 1'b1;
    full_v = 1'b1;
    step();
    full_v = 1'b0;
    repeat (2) step();
    drop_mask[0] = 1'b0;
    repeat (10) step();

    // 6: asynchronous reset during producer 2's burst
    do_reset();
    load(2, 6, 'hC0);
    repeat (3) step();
    #2 arst = 1'b1;
    #1;
    chk("t6_push", 32'(bus.push), 0);
    chk("t6_gnt",  32'(bus.gnt),  0);
    chk("t6_busy", 32'(bus.busy), 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) load(i, 6, 16 * i + 8);
    @(posedge clk); #1;
    arst = 1'b0;
    step();
    chk("t6_first_owner", 32'(bus.src_id), 0);
    chk("t6_first_busy",  32'(bus.busy),   1);
    repeat (8) step();

    // Randomized traffic with full back-pressure and occasional withdrawals
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ptr[i] >= len[i] && $urandom_range(0, 3) == 0) begin
          len[i] = $urandom_range(1, 12);
          ptr[i] = 0;
          for (int k = 0; k < 16; k++) data[i][k] = 8'($urandom);
        end
        drop_mask[i] = ($urandom_range(0, 15) == 0);
      end
      full_v = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
